// File: rtl/lab4_alu_pkg.sv
// -----------------------------------------------------------------------------
// lab4_alu_pkg
// Shared definitions for the Lab4 ALU arbiter: ALU function-select encodings,
// the arbiter FSM state type, and bit positions inside the ALU status word.
// No ports (package).
// -----------------------------------------------------------------------------
package lab4_alu_pkg;

  // ALU function-select encodings
  localparam logic [2:0] FS_AND     = 3'b000;
  localparam logic [2:0] FS_OR      = 3'b001;
  localparam logic [2:0] FS_XOR     = 3'b010;
  localparam logic [2:0] FS_NOR     = 3'b011;
  localparam logic [2:0] FS_ADD     = 3'b100;
  localparam logic [2:0] FS_SHL     = 3'b101;
  localparam logic [2:0] FS_SHR     = 3'b110;
  localparam logic [2:0] FS_ILLEGAL = 3'b111;

  // Arbiter sequencing: accept in IDLE, one ALU cycle in EXEC, hold in RESP
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Bit positions inside the 4-bit ALU status word
  localparam int STAT_Z = 0;  // result is zero
  localparam int STAT_N = 1;  // result MSB (negative)
  localparam int STAT_C = 2;  // carry out of ADD
  localparam int STAT_V = 3;  // signed overflow of ADD

  function automatic logic fs_is_illegal(input logic [2:0] fs);
    return fs == FS_ILLEGAL;
  endfunction

endpackage

// File: rtl/lab4_alu_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. The grant is purely combinational from the
// request vector and an internal preference bit; the preference only moves
// when 'update' is pulsed, and then favours the requester that did NOT own
// the last completed transaction.
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous active-low reset (preference -> requester 0)
//   req      in   2  request vector, bit N = requester N valid
//   last_id  in   1  requester that owned the transaction just completed
//   update   in   1  advance the preference using last_id
//   grant    out  2  one-hot grant (all zero when no request)
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       last_id,
  input  logic       update,
  output logic [1:0] grant
);

  logic r_favour1;  // 1: requester 1 wins a tie

  // NOTE: clocked state is always written with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_favour1 <= 1'b0;
    end else if (update) begin
      r_favour1 <= ~last_id;
    end
  end

  // NOTE: the output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_favour1 ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/lab4_alu_arbiter.sv
// -----------------------------------------------------------------------------
// lab4_alu_arbiter
// Shares one 32-bit Lab4 ALU between two requesters. Each requester offers an
// op on a valid/ready channel; a round-robin arbiter picks one, its operands
// are registered onto the ALU inputs, the ALU result is captured one cycle
// later and presented on a single registered response channel that is held
// until the consumer takes it. FS=111 is rejected without using the ALU and
// answered one cycle after accept with rsp_err=1.
//
// Optional feature macro: LAB4_ALU_ARB_PERF_EN
//   When defined, adds saturating per-requester accept counters perf_cnt0/1.
//
// Ports:
//   clk, rst_n                  clock / asynchronous active-low reset
//   reqN_valid/ready            request handshake, N = 0,1
//   reqN_a, reqN_b  [W]         operands
//   reqN_fs [3], reqN_c0        function select, carry-in
//   rsp_valid/ready             response handshake
//   rsp_id                      requester that issued the op
//   rsp_f [W], rsp_status [4]   captured ALU result / status
//   rsp_err                     op carried FS=111
//   alu_a, alu_b [W], alu_fs, alu_c0   registered ALU inputs
//   alu_f [W], alu_status [4]   combinational ALU outputs
//   perf_cnt0/1 [PERF_CNT_W]    accept counters (LAB4_ALU_ARB_PERF_EN only)
// -----------------------------------------------------------------------------
module lab4_alu_arbiter
  import lab4_alu_pkg::*;
#(
  parameter int W          = 32,
  parameter int PERF_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // requester 0
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [W-1:0]          req0_a,
  input  logic [W-1:0]          req0_b,
  input  logic [2:0]            req0_fs,
  input  logic                  req0_c0,
  // requester 1
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [W-1:0]          req1_a,
  input  logic [W-1:0]          req1_b,
  input  logic [2:0]            req1_fs,
  input  logic                  req1_c0,
  // response
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [W-1:0]          rsp_f,
  output logic [3:0]            rsp_status,
  output logic                  rsp_err,
  // ALU side
  output logic [W-1:0]          alu_a,
  output logic [W-1:0]          alu_b,
  output logic [2:0]            alu_fs,
  output logic                  alu_c0,
  input  logic [W-1:0]          alu_f,
  input  logic [3:0]            alu_status
`ifdef LAB4_ALU_ARB_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_cnt0,
  output logic [PERF_CNT_W-1:0] perf_cnt1
`endif
);

  if (PERF_CNT_W < 1) begin : g_bad_perf_cnt_w
    $error("PERF_CNT_W must be at least 1");
  end

  state_t         r_state;
  state_t         w_state_nxt;

  logic [1:0]     w_req;
  logic [1:0]     w_grant;
  logic           w_idle;
  logic           w_accept0;
  logic           w_accept1;
  logic           w_accept;
  logic           w_rsp_done;

  logic           w_sel_id;
  logic [W-1:0]   w_sel_a;
  logic [W-1:0]   w_sel_b;
  logic [2:0]     w_sel_fs;
  logic           w_sel_c0;
  logic           w_sel_illegal;

  logic [W-1:0]   r_alu_a;
  logic [W-1:0]   r_alu_b;
  logic [2:0]     r_alu_fs;
  logic           r_alu_c0;

  logic           r_rsp_valid;
  logic           r_rsp_id;
  logic           r_rsp_err;
  logic [W-1:0]   r_rsp_f;
  logic [3:0]     r_rsp_status;

  // ---------------------------------------------------------------------------
  // Arbitration and request handshake. Ready depends only on state and the
  // request valids, never on rsp_ready.
  // ---------------------------------------------------------------------------
  assign w_req = {req1_valid, req0_valid};

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (w_req),
    .last_id (r_rsp_id),
    .update  (w_rsp_done),
    .grant   (w_grant)
  );

  assign w_idle     = (r_state == ST_IDLE);
  assign req0_ready = w_idle & w_grant[0];
  assign req1_ready = w_idle & w_grant[1];

  assign w_accept0  = req0_valid & req0_ready;
  assign w_accept1  = req1_valid & req1_ready;
  assign w_accept   = w_accept0 | w_accept1;
  assign w_rsp_done = r_rsp_valid & rsp_ready;

  // Grant is one-hot, so bit 1 alone identifies the winner
  assign w_sel_id      = w_grant[1];
  assign w_sel_a       = w_sel_id ? req1_a  : req0_a;
  assign w_sel_b       = w_sel_id ? req1_b  : req0_b;
  assign w_sel_fs      = w_sel_id ? req1_fs : req0_fs;
  assign w_sel_c0      = w_sel_id ? req1_c0 : req0_c0;
  assign w_sel_illegal = fs_is_illegal(w_sel_fs);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_sel_illegal ? ST_RESP : ST_EXEC;
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: if (w_rsp_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath. The ALU input registers load only on a legal accept, so they are
  // steady through EXEC and RESP and keep the last legal op across an illegal
  // one. An illegal op builds its response directly at the accept edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_fs     <= '0;
      r_alu_c0     <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_f      <= '0;
      r_rsp_status <= '0;
    end else begin
      if (w_accept) begin
        r_rsp_id <= w_sel_id;
        if (w_sel_illegal) begin
          r_rsp_valid  <= 1'b1;
          r_rsp_err    <= 1'b1;
          r_rsp_f      <= '0;
          r_rsp_status <= '0;
        end else begin
          r_alu_a  <= w_sel_a;
          r_alu_b  <= w_sel_b;
          r_alu_fs <= w_sel_fs;
          r_alu_c0 <= w_sel_c0;
        end
      end

      if (r_state == ST_EXEC) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_err    <= 1'b0;
        r_rsp_f      <= alu_f;
        r_rsp_status <= alu_status;
      end

      if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_fs     = r_alu_fs;
  assign alu_c0     = r_alu_c0;

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_err    = r_rsp_err;
  assign rsp_f      = r_rsp_f;
  assign rsp_status = r_rsp_status;

`ifdef LAB4_ALU_ARB_PERF_EN
  // ---------------------------------------------------------------------------
  // Accept counters, legal and illegal ops alike; they stick at all-ones.
  // ---------------------------------------------------------------------------
  logic [PERF_CNT_W-1:0] r_perf_cnt0;
  logic [PERF_CNT_W-1:0] r_perf_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cnt0 <= '0;
      r_perf_cnt1 <= '0;
    end else begin
      if (w_accept0 && (r_perf_cnt0 != '1)) r_perf_cnt0 <= r_perf_cnt0 + 1'b1;
      if (w_accept1 && (r_perf_cnt1 != '1)) r_perf_cnt1 <= r_perf_cnt1 + 1'b1;
    end
  end

  assign perf_cnt0 = r_perf_cnt0;
  assign perf_cnt1 = r_perf_cnt1;
`endif

endmodule

// File: tb/tb_lab4_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lab4_alu_arbiter
// Bench for lab4_alu_arbiter together with a behavioural Lab4 ALU. Directed
// scenarios cover reset, the basic logic ops, round-robin alternation, the
// illegal FS path, response back-pressure and reset during EXEC; a randomized
// phase compares every cycle against a transaction-level reference model.
// With LAB4_ALU_ARB_PERF_EN defined the counters are built 2 bits wide and
// their saturation is checked.
// -----------------------------------------------------------------------------
module tb_lab4_alu_arbiter;
  import lab4_alu_pkg::*;

  localparam int W = 32;
`ifdef LAB4_ALU_ARB_PERF_EN
  localparam int PCW = 2;
`else
  localparam int PCW = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_c0;
  logic [W-1:0]  req0_a, req0_b;
  logic [2:0]    req0_fs;
  logic          req1_valid, req1_ready, req1_c0;
  logic [W-1:0]  req1_a, req1_b;
  logic [2:0]    req1_fs;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0]  rsp_f;
  logic [3:0]    rsp_status;
  logic [W-1:0]  alu_a, alu_b, alu_f;
  logic [2:0]    alu_fs;
  logic          alu_c0;
  logic [3:0]    alu_status;
  logic [32:0]   alu_sum;
`ifdef LAB4_ALU_ARB_PERF_EN
  logic [PCW-1:0] perf_cnt0, perf_cnt1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lab4_alu_arbiter #(.W(W), .PERF_CNT_W(PCW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_fs    (req0_fs),
    .req0_c0    (req0_c0),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_fs    (req1_fs),
    .req1_c0    (req1_c0),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_f      (rsp_f),
    .rsp_status (rsp_status),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_fs     (alu_fs),
    .alu_c0     (alu_c0),
    .alu_f      (alu_f),
    .alu_status (alu_status)
`ifdef LAB4_ALU_ARB_PERF_EN
    ,
    .perf_cnt0  (perf_cnt0),
    .perf_cnt1  (perf_cnt1)
`endif
  );

  // Behavioural Lab4 ALU driven by the arbiter's registered outputs
  always_comb begin
    alu_sum    = '0;
    alu_f      = '0;
    alu_status = '0;
    case (alu_fs)
      FS_AND: alu_f = alu_a & alu_b;
      FS_OR:  alu_f = alu_a | alu_b;
      FS_XOR: alu_f = alu_a ^ alu_b;
      FS_NOR: alu_f = ~(alu_a | alu_b);
      FS_ADD: begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_c0};
        alu_f   = alu_sum[31:0];
        alu_status[STAT_C] = alu_sum[32];
        alu_status[STAT_V] = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
      end
      FS_SHL: alu_f = alu_a << alu_b[4:0];
      FS_SHR: alu_f = alu_a >> alu_b[4:0];
      default: alu_f = '0;
    endcase
    alu_status[STAT_N] = alu_f[31];
    alu_status[STAT_Z] = (alu_f == '0);
  end

  // Reference result {status, f} computed with wide integer arithmetic
  function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] fs, input logic c0);
    logic [31:0]     f;
    logic [3:0]      st;
    longint unsigned usum;
    longint          ssum;
    f  = '0;
    st = '0;
    case (fs)
      FS_AND: f = a & b;
      FS_OR:  f = a | b;
      FS_XOR: f = a ^ b;
      FS_NOR: f = ~(a | b);
      FS_ADD: begin
        usum = longint'(a) + longint'(b) + longint'(c0);
        ssum = longint'($signed(a)) + longint'($signed(b)) + longint'(c0);
        f = usum[31:0];
        st[STAT_C] = usum[32];
        st[STAT_V] = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
      end
      FS_SHL: f = a << b[4:0];
      FS_SHR: f = a >> b[4:0];
      default: f = '0;
    endcase
    st[STAT_N] = f[31];
    st[STAT_Z] = (f == 32'd0);
    return {st, f};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_fs = '0; req0_c0 = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_fs = '0; req1_c0 = 1'b0;
    rsp_ready  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) $display("FAIL reset_handshake: got %b want 000", {req0_ready, req1_ready, rsp_valid}); else n_pass++;
    n_checks++; if ({rsp_id, rsp_err, rsp_status, rsp_f} !== 38'd0) $display("FAIL reset_rsp: got %0h want 0", {rsp_id, rsp_err, rsp_status, rsp_f}); else n_pass++;
    n_checks++; if ({alu_a, alu_b, alu_fs, alu_c0} !== 68'd0) $display("FAIL reset_alu: got %0h want 0", {alu_a, alu_b, alu_fs, alu_c0}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // A=15, B=10 through AND, OR, XOR from requester 0
  task automatic test_basic_ops();
    logic [31:0] exp_tbl [3];
    logic [35:0] exp_r;
    exp_tbl = '{32'd10, 32'd15, 32'd5};
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req0_valid = 1'b1; req0_a = 32'd15; req0_b = 32'd10; req0_fs = k[2:0]; req0_c0 = 1'b0;
      exp_r = ref_alu(32'd15, 32'd10, k[2:0], 1'b0);
      #1;
      n_checks++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL basic_ready op%0d: got %b want 01", k, {req1_ready, req0_ready}); else n_pass++;
      tick();
      req0_valid = 1'b0;
      #1;
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL basic_early_valid op%0d: got %b want 0", k, rsp_valid); else n_pass++;
      n_checks++; if ({alu_a, alu_b, alu_fs, alu_c0} !== {32'd15, 32'd10, k[2:0], 1'b0}) $display("FAIL basic_alu_in op%0d: got %0h want %0h", k, {alu_a, alu_b, alu_fs, alu_c0}, {32'd15, 32'd10, k[2:0], 1'b0}); else n_pass++;
      tick();
      n_checks++; if (rsp_valid !== 1'b1) $display("FAIL basic_latency op%0d: got %b want 1", k, rsp_valid); else n_pass++;
      n_checks++; if (rsp_f !== exp_tbl[k]) $display("FAIL basic_f op%0d: got %0d want %0d", k, rsp_f, exp_tbl[k]); else n_pass++;
      n_checks++; if ({rsp_id, rsp_err, rsp_status} !== {1'b0, 1'b0, exp_r[35:32]}) $display("FAIL basic_id_err_st op%0d: got %b want %b", k, {rsp_id, rsp_err, rsp_status}, {1'b0, 1'b0, exp_r[35:32]}); else n_pass++;
      tick();
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL basic_release op%0d: got %b want 0", k, rsp_valid); else n_pass++;
    end
    rsp_ready = 1'b0;
  endtask

  // Both requesters always valid: grants alternate, one op every 3 cycles
  task automatic test_alternate();
    logic        exp_id;
    logic [35:0] exp_r;
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_fs = FS_ADD; req0_c0 = 1'($urandom);
      req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_fs = FS_XOR; req1_c0 = 1'($urandom);
      exp_id = k[0];
      exp_r  = exp_id ? ref_alu(req1_a, req1_b, req1_fs, req1_c0) : ref_alu(req0_a, req0_b, req0_fs, req0_c0);
      #1;
      n_checks++; if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) $display("FAIL alt_grant op%0d: got %b want %b", k, {req1_ready, req0_ready}, (exp_id ? 2'b10 : 2'b01)); else n_pass++;
      tick();
      n_checks++; if ({req1_ready, req0_ready} !== 2'b00) $display("FAIL alt_exec_ready op%0d: got %b want 00", k, {req1_ready, req0_ready}); else n_pass++;
      tick();
      n_checks++; if ({rsp_valid, rsp_id} !== {1'b1, exp_id}) $display("FAIL alt_rsp_id op%0d: got %b want %b", k, {rsp_valid, rsp_id}, {1'b1, exp_id}); else n_pass++;
      n_checks++; if ({rsp_status, rsp_f} !== exp_r) $display("FAIL alt_rsp_data op%0d: got %0h want %0h", k, {rsp_status, rsp_f}, exp_r); else n_pass++;
      tick();
    end
    clear_inputs();
  endtask

  // Legal op from req0, then FS=111 from req1
  task automatic test_illegal();
    logic [31:0] la, lb;
    logic        lc;
    la = $urandom; lb = $urandom; lc = 1'($urandom);
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = la; req0_b = lb; req0_fs = FS_ADD; req0_c0 = lc;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    req1_valid = 1'b1; req1_a = ~la; req1_b = ~lb; req1_fs = FS_ILLEGAL; req1_c0 = ~lc;
    #1;
    n_checks++; if ({req1_ready, req0_ready} !== 2'b10) $display("FAIL ill_ready: got %b want 10", {req1_ready, req0_ready}); else n_pass++;
    tick();
    req1_valid = 1'b0;
    #1;
    n_checks++; if ({rsp_valid, rsp_err, rsp_id} !== 3'b111) $display("FAIL ill_latency_err_id: got %b want 111", {rsp_valid, rsp_err, rsp_id}); else n_pass++;
    n_checks++; if ({rsp_status, rsp_f} !== 36'd0) $display("FAIL ill_data: got %0h want 0", {rsp_status, rsp_f}); else n_pass++;
    n_checks++; if ({alu_a, alu_b, alu_fs, alu_c0} !== {la, lb, FS_ADD, lc}) $display("FAIL ill_alu_kept: got %0h want %0h", {alu_a, alu_b, alu_fs, alu_c0}, {la, lb, FS_ADD, lc}); else n_pass++;
    tick();
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL ill_release: got %b want 0", rsp_valid); else n_pass++;
    clear_inputs();
  endtask

  // Response stalled for 5 cycles with both requesters still asking
  task automatic test_backpressure();
    logic [31:0] la, lb;
    logic [35:0] exp_r;
    la = $urandom; lb = $urandom;
    exp_r = ref_alu(la, lb, FS_SHL, 1'b0);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = la; req0_b = lb; req0_fs = FS_SHL; req0_c0 = 1'b0;
    req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_fs = FS_OR; req1_c0 = 1'b0;
    #1;
    n_checks++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL bp_grant: got %b want 01", {req1_ready, req0_ready}); else n_pass++;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      #1;
      n_checks++; if ({rsp_valid, req1_ready, req0_ready} !== 3'b100) $display("FAIL bp_hold_hs cyc%0d: got %b want 100", k, {rsp_valid, req1_ready, req0_ready}); else n_pass++;
      n_checks++; if ({rsp_id, rsp_err, rsp_status, rsp_f} !== {1'b0, 1'b0, exp_r}) $display("FAIL bp_hold_rsp cyc%0d: got %0h want %0h", k, {rsp_id, rsp_err, rsp_status, rsp_f}, {1'b0, 1'b0, exp_r}); else n_pass++;
      n_checks++; if ({alu_a, alu_b, alu_fs} !== {la, lb, FS_SHL}) $display("FAIL bp_alu_stable cyc%0d: got %0h want %0h", k, {alu_a, alu_b, alu_fs}, {la, lb, FS_SHL}); else n_pass++;
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid_at_release: got %b want 1", rsp_valid); else n_pass++;
    tick();
    n_checks++; if ({rsp_valid, req1_ready, req0_ready} !== 3'b010) $display("FAIL bp_after_release: got %b want 010", {rsp_valid, req1_ready, req0_ready}); else n_pass++;
    clear_inputs();
  endtask

  // Reset while an op from req1 sits in EXEC; pointer was favouring req1
  task automatic test_reset_mid_op();
    req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_fs = FS_AND; req1_c0 = 1'b0;
    #1;
    n_checks++; if (req1_ready !== 1'b1) $display("FAIL rst_mid_accept: got %b want 1", req1_ready); else n_pass++;
    tick();
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    rst_n      = 1'b0;
    #1;
    n_checks++; if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_status, rsp_f} !== 41'd0) $display("FAIL rst_mid_rsp: got %0h want 0", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_status, rsp_f}); else n_pass++;
    n_checks++; if ({alu_a, alu_b, alu_fs, alu_c0} !== 68'd0) $display("FAIL rst_mid_alu: got %0h want 0", {alu_a, alu_b, alu_fs, alu_c0}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_mid_no_rsp cyc%0d: got %b want 0", k, rsp_valid); else n_pass++;
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_checks++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL rst_mid_ptr: got %b want 01", {req1_ready, req0_ready}); else n_pass++;
    clear_inputs();
  endtask

  // Randomized traffic against a transaction-level model
  typedef struct packed {
    logic        id;
    logic        err;
    logic [3:0]  st;
    logic [31:0] f;
  } exp_rsp_t;

  task automatic test_random();
    logic        m_favour1, m_busy, e0, e1, ev, win;
    int          m_due;
    exp_rsp_t    m_rsp;
    logic [67:0] m_alu;
    logic [35:0] r;
    do_reset();
    m_favour1 = 1'b0; m_busy = 1'b0; m_due = 0; m_rsp = '0; m_alu = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_a = $urandom; req0_b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      req1_a = $urandom; req1_b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      req0_fs = 3'($urandom_range(0, 7)); req1_fs = 3'($urandom_range(0, 7));
      req0_c0 = 1'($urandom); req1_c0 = 1'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      e0 = 1'b0; e1 = 1'b0;
      if (!m_busy) begin
        if (req0_valid && req1_valid) begin e1 = m_favour1; e0 = !m_favour1; end
        else begin e0 = req0_valid; e1 = req1_valid; end
      end
      ev = m_busy && (cyc >= m_due);
      n_checks++; if ({req1_ready, req0_ready} !== {e1, e0}) $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc, {req1_ready, req0_ready}, {e1, e0}); else n_pass++;
      n_checks++; if (rsp_valid !== ev) $display("FAIL rnd_valid cyc%0d: got %b want %b", cyc, rsp_valid, ev); else n_pass++;
      if (ev) begin
        n_checks++; if ({rsp_id, rsp_err, rsp_status, rsp_f} !== m_rsp) $display("FAIL rnd_rsp cyc%0d: got %0h want %0h", cyc, {rsp_id, rsp_err, rsp_status, rsp_f}, m_rsp); else n_pass++;
      end
      n_checks++; if ({alu_a, alu_b, alu_fs, alu_c0} !== m_alu) $display("FAIL rnd_alu cyc%0d: got %0h want %0h", cyc, {alu_a, alu_b, alu_fs, alu_c0}, m_alu); else n_pass++;
      if (ev && rsp_ready) begin
        m_busy    = 1'b0;
        m_favour1 = !m_rsp.id;
      end else if (e0 || e1) begin
        win    = e1;
        m_busy = 1'b1;
        if ((win ? req1_fs : req0_fs) == FS_ILLEGAL) begin
          m_rsp = '{id: win, err: 1'b1, st: 4'd0, f: 32'd0};
          m_due = cyc + 1;
        end else begin
          m_alu = win ? {req1_a, req1_b, req1_fs, req1_c0} : {req0_a, req0_b, req0_fs, req0_c0};
          r     = win ? ref_alu(req1_a, req1_b, req1_fs, req1_c0) : ref_alu(req0_a, req0_b, req0_fs, req0_c0);
          m_rsp = '{id: win, err: 1'b0, st: r[35:32], f: r[31:0]};
          m_due = cyc + 2;
        end
      end
      tick();
    end
    clear_inputs();
  endtask

`ifdef LAB4_ALU_ARB_PERF_EN
  // Five accepts by req0 into a 2-bit counter
  task automatic test_perf();
    do_reset();
    n_checks++; if ({perf_cnt0, perf_cnt1} !== '0) $display("FAIL perf_reset: got %0h want 0", {perf_cnt0, perf_cnt1}); else n_pass++;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_fs = FS_AND; req0_c0 = 1'b0;
      tick();
      req0_valid = 1'b0;
      tick();
      tick();
      if (k == 0) begin
        n_checks++; if (perf_cnt0 !== 2'd1) $display("FAIL perf_first: got %0d want 1", perf_cnt0); else n_pass++;
      end
    end
    n_checks++; if (perf_cnt0 !== 2'd3) $display("FAIL perf_cnt0_sat: got %0d want 3", perf_cnt0); else n_pass++;
    n_checks++; if (perf_cnt1 !== 2'd0) $display("FAIL perf_cnt1: got %0d want 0", perf_cnt1); else n_pass++;
    clear_inputs();
  endtask
`endif

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    #2;
    test_reset();
    test_basic_ops();
    test_alternate();
    test_illegal();
    test_backpressure();
    test_reset_mid_op();
    test_random();
`ifdef LAB4_ALU_ARB_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
